// File: rtl/main_memory.sv
// main_memory
// Word-organised backing store with a fixed access latency, serving block
// fills (reads) and dirty-block write-backs (writes) for the upstream cache
// controller over a single req/rw/rdy handshake. It also keeps saturating
// counters of completed reads and writes.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (does not clear the storage array)
//   memaddr  byte address; word index is memaddr[ADDR_W-1:2]
//   req      access request, sampled only while idle
//   rw       1 = write block, 0 = read block
//   datain   write data
//   dataout  registered read data, holds the last completed read
//   rdy      registered one-cycle completion pulse
//   busy     high while an access is in flight or being reported
//   rd_cnt   completed reads, saturating at 16'hFFFF
//   wr_cnt   completed writes, saturating at 16'hFFFF
//
// LATENCY is the number of cycles from request capture to the completion
// edge and must lie in 1..15.

module main_memory #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic              req,
    input  logic              rw,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              rdy,
    output logic              busy,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int         IDX_W    = ADDR_W - 2;
    localparam int         DEPTH    = 2 ** IDX_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              capture;
    logic              complete;
    logic [3:0]        cnt;

    logic [IDX_W-1:0]  cap_idx;
    logic              cap_rw;
    logic [DATA_W-1:0] cap_data;

    // Each word is stored XORed with its own index, so an array that powers
    // up all-zero reads back as word i = i without any initialisation pass,
    // and rst never has to touch the array.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] idx_pattern;

    // The two byte-offset bits never select anything.
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^memaddr[1:0];
    assign idx_pattern      = DATA_W'(cap_idx);
    assign busy             = (state == BUSY) || (state == RESP);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; capture and complete mark the edges at which a
    // request is latched and at which the array access happens.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    complete   = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture; once latched, later input changes have no effect.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_idx  <= memaddr[ADDR_W-1:2];
            cap_rw   <= rw;
            cap_data <= datain;
        end
    end

    // Latency counter, completion pulse, read data and access counters.
    // rst wins over a completing access, so an aborted access leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            rdy     <= 1'b0;
            dataout <= '0;
            rd_cnt  <= 16'd0;
            wr_cnt  <= 16'd0;
        end else begin
            rdy <= complete;
            if (capture) begin
                cnt <= CNT_LOAD;
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (complete) begin
                if (!cap_rw) begin
                    dataout <= mem[cap_idx] ^ idx_pattern;
                    if (rd_cnt != 16'hFFFF) begin
                        rd_cnt <= rd_cnt + 16'd1;
                    end
                end else if (wr_cnt != 16'hFFFF) begin
                    wr_cnt <= wr_cnt + 16'd1;
                end
            end
        end
    end

    // Array write at the completion edge of a write access.
    always_ff @(posedge clk) begin
        if (!rst && complete && cap_rw) begin
            mem[cap_idx] <= cap_data ^ idx_pattern;
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory
// Randomised, scoreboard-based bench for main_memory. The reference model is
// a sparse word array (unwritten words read back as their own index) plus
// saturating read/write counts. Expected responses are queued when a request
// is issued and a monitor pops them whenever rdy is seen.

module tb_main_memory;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [15:0] memaddr;
    logic        req;
    logic        rw;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        rdy;
    logic        busy;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    main_memory #(
        .ADDR_W (16),
        .DATA_W (32),
        .LATENCY(LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .memaddr(memaddr),
        .req    (req),
        .rw     (rw),
        .datain (datain),
        .dataout(dataout),
        .rdy    (rdy),
        .busy   (busy),
        .rd_cnt (rd_cnt),
        .wr_cnt (wr_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [15:0] rdc;
        logic [15:0] wrc;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] model_mem [int unsigned];
    logic [31:0] model_dout;
    logic [15:0] model_rd;
    logic [15:0] model_wr;
    int          compared;
    int          mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input int unsigned idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return 32'(idx);
    endfunction

    // Update the model for one access and queue the response it must produce.
    task automatic modelAccess(input logic isWrite, input logic [15:0] addr,
                               input logic [31:0] data);
        resp_t       e;
        int unsigned idx;
        idx = 32'(addr[15:2]);
        if (isWrite) begin
            model_mem[idx] = data;
            if (model_wr != 16'hFFFF) model_wr = model_wr + 16'd1;
        end else begin
            model_dout = modelRead(idx);
            if (model_rd != 16'hFFFF) model_rd = model_rd + 16'd1;
        end
        e.data = model_dout;
        e.rdc  = model_rd;
        e.wrc  = model_wr;
        sb.push_back(e);
    endtask

    // Monitor: every rdy pulse must match the oldest queued response.
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_rdy: got rdy=1, expected no pending access");
            end else begin
                resp_t e;
                e = sb.pop_front();
                checkOutput("resp_dataout", dataout, e.data);
                checkOutput("resp_rd_cnt", 32'(rd_cnt), 32'(e.rdc));
                checkOutput("resp_wr_cnt", 32'(wr_cnt), 32'(e.wrc));
            end
        end
    end

    // Issue one access from a negedge with the DUT idle, scramble all inputs
    // while it is in flight, and check busy/rdy timing and dataout holding.
    task automatic applyStimulus(input logic isWrite, input logic [15:0] addr,
                                 input logic [31:0] data);
        logic [31:0] prevDout;
        prevDout = model_dout;
        modelAccess(isWrite, addr, data);
        req     = 1'b1;
        rw      = isWrite;
        memaddr = addr;
        datain  = data;
        @(posedge clk);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            checkOutput("busy_during_access", 32'(busy), 32'd1);
            checkOutput("rdy_timing", 32'(rdy), (k == LAT + 1) ? 32'd1 : 32'd0);
            if (k <= LAT) checkOutput("dataout_hold", dataout, prevDout);
            req     = 1'($urandom_range(0, 1));
            rw      = 1'($urandom_range(0, 1));
            memaddr = 16'($urandom);
            datain  = $urandom;
        end
        @(negedge clk);
        checkOutput("busy_after_access", 32'(busy), 32'd0);
        checkOutput("rdy_after_access", 32'(rdy), 32'd0);
        req = 1'b0;
    endtask

    // Three reads with req held high throughout: one capture every LAT+2 cycles.
    task automatic backToBack(input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2);
        logic [15:0] addrs [3];
        int          period;
        period   = LAT + 2;
        addrs[0] = a0;
        addrs[1] = a1;
        addrs[2] = a2;
        for (int i = 0; i < 3; i++) modelAccess(1'b0, addrs[i], 32'd0);
        req     = 1'b1;
        rw      = 1'b0;
        memaddr = addrs[0];
        for (int k = 1; k <= 3 * period; k++) begin
            @(negedge clk);
            checkOutput("b2b_rdy", 32'(rdy), ((k % period) == LAT + 1) ? 32'd1 : 32'd0);
            checkOutput("b2b_busy", 32'(busy), ((k % period) != 0) ? 32'd1 : 32'd0);
            if ((k % period) == 0 && k < 3 * period) memaddr = addrs[k / period];
            if (k == 3 * period) req = 1'b0;
        end
    endtask

    // Write whose completion edge coincides with rst: nothing may happen.
    task automatic resetAtCompletion();
        req     = 1'b1;
        rw      = 1'b1;
        memaddr = 16'h0020;
        datain  = 32'h1111_1111;
        @(posedge clk);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (k == LAT) rst = 1'b1;
        end
        @(negedge clk);
        rst        = 1'b0;
        model_rd   = 16'd0;
        model_wr   = 16'd0;
        model_dout = 32'd0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_wr_cnt", 32'(wr_cnt), 32'(model_wr));
        checkOutput("abort_dataout", dataout, model_dout);
        for (int k = 0; k < 3; k++) begin
            checkOutput("abort_no_rdy", 32'(rdy), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        model_rd   = 16'd0;
        model_wr   = 16'd0;
        model_dout = 32'd0;
        rst        = 1'b1;
        req        = 1'b0;
        rw         = 1'b0;
        memaddr    = 16'd0;
        datain     = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdy", 32'(rdy), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_dataout", dataout, 32'd0);
        checkOutput("reset_rd_cnt", 32'(rd_cnt), 32'd0);
        checkOutput("reset_wr_cnt", 32'(wr_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 16'h0010, 32'd0);
        applyStimulus(1'b1, 16'h1234, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 16'h1236, 32'd0);

        $display("[TB] reset at completion edge");
        resetAtCompletion();
        applyStimulus(1'b0, 16'h0020, 32'd0);

        $display("[TB] back-to-back reads");
        backToBack(16'h0010, 16'h1234, 16'h0403);
        @(negedge clk);

        $display("[TB] random accesses");
        for (int n = 0; n < 60; n++) begin
            logic [15:0] addr;
            addr = 16'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), addr, $urandom);
            repeat ($urandom_range(0, 2)) begin
                memaddr = 16'($urandom);
                datain  = $urandom;
                @(negedge clk);
                checkOutput("idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("[TB] read counter saturation");
        force dut.rd_cnt = 16'hFFFD;
        @(posedge clk);
        @(negedge clk);
        release dut.rd_cnt;
        model_rd = 16'hFFFD;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 16'(n * 4 + 1), 32'd0);
        end

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
